muldiv_ctrl: RTL

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Optional MULDIV_FAST_MULT_EN: multiplies finish in one cycle via a combinational 64-bit product.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [63:0] work_q, work_d;
    logic        neg_lo_q, neg_lo_d;
    logic        neg_hi_q, neg_hi_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        div_zero_q, div_zero_d;

    logic        is_div, is_signed, sign_a, sign_b;
    logic [31:0] mag_a, mag_b;

    assign is_div    = op[1];
    assign is_signed = ~op[0];
    assign sign_a    = is_signed & rs_val[31];
    assign sign_b    = is_signed & rt_val[31];
    assign mag_a     = sign_a ? (~rs_val + 32'd1) : rs_val;
    assign mag_b     = sign_b ? (~rt_val + 32'd1) : rt_val;

    // work_q holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide
    logic [32:0] mul_sum, div_rem, div_diff;
    assign mul_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, mcand_q} : 33'd0);
    assign div_rem  = {work_q[63:32], work_q[31]};
    assign div_diff = div_rem - {1'b0, mcand_q};

    logic [63:0] prod_mag, prod_fix;
`ifdef MULDIV_FAST_MULT_EN
    assign prod_mag = {32'd0, mcand_q} * {32'd0, work_q[31:0]};
`else
    assign prod_mag = work_q;
`endif
    assign prod_fix = neg_lo_q ? (~prod_mag + 64'd1) : prod_mag;

    logic [31:0] quo_fix, rem_fix, dvd_fix;
    assign quo_fix = neg_lo_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];
    assign rem_fix = neg_hi_q ? (~work_q[63:32] + 32'd1) : work_q[63:32];
    // on divide-by-zero the dividend magnitude is left untouched, so this rebuilds rs_val
    assign dvd_fix = neg_hi_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        work_d     = work_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = op;
                    mcand_d  = is_div ? mag_b : mag_a;
                    work_d   = {32'd0, (is_div ? mag_a : mag_b)};
                    neg_lo_d = sign_a ^ sign_b;
                    neg_hi_d = sign_a;
                    dz_d     = is_div & (rt_val == 32'd0);
                    cnt_d    = 6'd0;
                    state_d  = RUN;
`ifdef MULDIV_FAST_MULT_EN
                    if (!is_div) state_d = FIX;
`endif
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 6'd1;
                if (!op_q[1]) begin
                    work_d = {mul_sum, work_q[31:1]};
                end else if (!dz_q) begin
                    work_d = {(div_diff[32] ? div_rem[31:0] : div_diff[31:0]),
                              work_q[30:0], ~div_diff[32]};
                end
                if (cnt_q == 6'd31) begin
                    cnt_d   = 6'd0;
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (op_q[1]) begin
                    if (dz_q) begin
                        lo_d       = 32'hFFFF_FFFF;
                        hi_d       = dvd_fix;
                        div_zero_d = 1'b1;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= 2'd0;
            cnt_q      <= 6'd0;
            mcand_q    <= 32'd0;
            work_q     <= 64'd0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            work_q     <= work_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
endmodule
